// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, stall and sequencing controller for the 5-stage core.
// Produces operand forwarding selects, per-stage stall/flush enables and the
// data-memory strobe. Two sequential engines live here as well: a memory
// wait tracker that raises a sticky timeout flag, and a halt/drain FSM that
// quiesces the pipeline on request without dropping an instruction.
//
// Handshake: dmem_req is a strobe that stays high while the access in M is
// outstanding; the access completes in the first cycle where dmem_req and
// dmem_ready are both high. Every cycle with dmem_req high and dmem_ready
// low is one stall cycle for F/D/E/M with a bubble into W.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       LoadE,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       dmem_ready,
  input  logic       halt_req,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       dmem_req,
  output logic       halted,
  output logic       mem_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Number of non-stalled DRAIN cycles counted before entering HALTED.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q;
  logic [1:0]       drain_cnt_q;
  logic             halted_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             mem_err_q;
  logic             mem_err_d;

  logic             lwstall;
  logic             memstall;
  logic             not_run;
  logic             drain_branch;

  // Forward from M first (youngest producer), then W; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (we_m && (rd_m == rs)) begin
        sel = FWD_MEM;
      end else if (we_w && (rd_w == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  // Operand forwarding selects for both ALU inputs.
  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // Hazard terms: a taken branch in E squashes the dependent D instruction,
  // so a load-use stall is pointless then and is suppressed.
  always_comb begin
    lwstall      = LoadE && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
    memstall     = MemReqM && !dmem_ready;
    not_run      = (state_q != ST_RUN);
    drain_branch = (state_q == ST_DRAIN) && PCSrcE;
  end

  // Stall/flush enables. memstall freezes F..M and overrides all flushes
  // except W, which receives bubbles while M waits on memory.
  always_comb begin
    dmem_req = MemReqM;
    StallF   = lwstall || memstall || (not_run && !drain_branch);
    StallD   = lwstall || memstall || not_run;
    StallE   = memstall;
    StallM   = memstall;
    FlushD   = PCSrcE && !memstall;
    FlushE   = (PCSrcE || lwstall || not_run) && !memstall;
    FlushW   = memstall;
  end

  // Wait counter next state: saturating count of consecutive memstall
  // cycles; the timeout flag is sticky until reset and never aborts the stall.
  always_comb begin
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;
    if (memstall) begin
      if (&wait_cnt_q) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (wait_cnt_q == WAIT_LAST) begin
        mem_err_d = 1'b1;
      end
    end
  end

  // Memory wait tracker registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Halt/drain FSM with registered halted output. D is held during DRAIN,
  // so abandoning the drain when halt_req drops loses nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 2'd0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          halted_q <= 1'b0;
          if (halt_req) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= 2'd0;
          end
        end
        ST_DRAIN: begin
          if (!halt_req) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end else if (!memstall) begin
            if (drain_cnt_q == DRAIN_LAST) begin
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q + 2'd1;
            end
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          drain_cnt_q <= 2'd0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  assign halted    = halted_q;
  assign mem_err   = mem_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl: forwarding, load-use, branch flush,
// memory wait and timeout, halt/drain sequencing and asynchronous reset.
module tb_pipeline_ctrl;

  localparam logic [7:0] S_RUN    = 8'd0;
  localparam logic [7:0] S_DRAIN  = 8'd1;
  localparam logic [7:0] S_HALTED = 8'd2;

  logic       clk;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, dmem_ready, halt_req;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic       dmem_req, halted, mem_err;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  pipeline_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .dmem_ready(dmem_ready), .halt_req(halt_req),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .dmem_req(dmem_req), .halted(halted), .mem_err(mem_err),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; dmem_ready = 1'b1;
  endtask

  // Advance to just after the next rising edge; inputs set after this apply
  // to the new cycle and are checked at the following falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    halt_req = 1'b0;
    idle_inputs();
    #3;
    check("rst_halted", halted, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_state", dbg_state, S_RUN);
    check("rst_stallF", StallF, 0);
    @(negedge clk);
    reset = 1'b1;

    // Forwarding
    next_cycle();
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
    @(negedge clk); check("fwdA_mem", ForwardAE, 8'b10);
    RegWriteM = 1'b0; RdM = 5'd0; RdW = 5'd5; RegWriteW = 1'b1;
    #1; check("fwdA_wb", ForwardAE, 8'b01);
    RdM = 5'd5; RegWriteM = 1'b1;
    #1; check("fwdA_mem_prio", ForwardAE, 8'b10);
    Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0;
    #1; check("fwdA_x0", ForwardAE, 8'b00);
    idle_inputs(); Rs2E = 5'd9; RdW = 5'd9; RegWriteW = 1'b1;
    #1; check("fwdB_wb", ForwardBE, 8'b01);
    RdM = 5'd9; RegWriteM = 1'b0;
    #1; check("fwdB_wb_mwe0", ForwardBE, 8'b01);
    RegWriteW = 1'b0;
    #1; check("fwdB_none", ForwardBE, 8'b00);

    // Load-use: one bubble cycle
    next_cycle();
    idle_inputs(); LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    @(negedge clk);
    check("lw_stallF", StallF, 1);
    check("lw_stallD", StallD, 1);
    check("lw_flushE", FlushE, 1);
    check("lw_flushD", FlushD, 0);
    next_cycle();
    LoadE = 1'b0; RdE = 5'd0;
    @(negedge clk);
    check("lw_after_stallF", StallF, 0);
    check("lw_after_flushE", FlushE, 0);
    LoadE = 1'b1; RdE = 5'd7; PCSrcE = 1'b1;
    #1;
    check("lw_br_stallF", StallF, 0);
    check("lw_br_flushD", FlushD, 1);
    check("lw_br_flushE", FlushE, 1);
    PCSrcE = 1'b0; RdE = 5'd0; Rs2D = 5'd0;
    #1; check("lw_rd0_stallF", StallF, 0);

    // Memory wait: three not-ready cycles, then release
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle_inputs(); MemReqM = 1'b1; dmem_ready = 1'b0;
      PCSrcE = (i == 1);
      LoadE = (i == 2); RdE = 5'd3; Rs1D = 5'd3;
      @(negedge clk);
      check("mw_stallF", StallF, 1);
      check("mw_stallM", StallM, 1);
      check("mw_stallE", StallE, 1);
      check("mw_flushW", FlushW, 1);
      check("mw_flushE", FlushE, 0);
      check("mw_flushD", FlushD, 0);
      check("mw_req", dmem_req, 1);
    end
    next_cycle();
    idle_inputs(); MemReqM = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    check("mw_rel_stallM", StallM, 0);
    check("mw_rel_flushW", FlushW, 0);
    check("mw_rel_req", dmem_req, 1);
    check("mw_rel_err", mem_err, 0);

    // Timeout: 16 not-ready cycles set the sticky flag
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      idle_inputs(); MemReqM = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      check("to_err_pre", mem_err, 0);
    end
    next_cycle();
    idle_inputs(); MemReqM = 1'b1; dmem_ready = 1'b1;
    @(negedge clk); check("to_err_set", mem_err, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle_inputs();
      @(negedge clk); check("to_err_sticky", mem_err, 1);
    end
    do_reset();
    check("to_err_reset", mem_err, 0);

    // Halt: DRAIN at t+1, halted at t+4, back to RUN after halt_req drops
    next_cycle();
    idle_inputs(); halt_req = 1'b1;
    @(negedge clk);
    check("h_t_flushE", FlushE, 0);
    check("h_t_halted", halted, 0);
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("h_seq_halted", halted, exp_q.pop_front());
      if (i == 0) begin
        check("h_drain_state", dbg_state, S_DRAIN);
        check("h_drain_flushE", FlushE, 1);
        check("h_drain_stallF", StallF, 1);
        check("h_drain_stallD", StallD, 1);
      end
    end
    check("h_halted_state", dbg_state, S_HALTED);
    check("h_halted_flushE", FlushE, 1);
    next_cycle();
    halt_req = 1'b0;
    @(negedge clk); check("h_drop_still", halted, 1);
    next_cycle();
    @(negedge clk);
    check("h_drop_halted", halted, 0);
    check("h_drop_state", dbg_state, S_RUN);
    check("h_drop_stallF", StallF, 0);

    // Halt with a 2-cycle memstall during DRAIN: halted at t+6
    next_cycle();
    idle_inputs(); halt_req = 1'b1;
    @(negedge clk);
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      MemReqM = (i == 1 || i == 2);
      dmem_ready = !(i == 1 || i == 2);
      @(negedge clk);
      check("hm_seq_halted", halted, exp_q.pop_front());
      if (i == 1) begin
        check("hm_ms_flushE", FlushE, 0);
        check("hm_ms_stallM", StallM, 1);
      end
    end
    idle_inputs();
    // Async reset while HALTED drops halted at once
    reset = 1'b0;
    #1;
    check("hm_areset_halted", halted, 0);
    check("hm_areset_state", dbg_state, S_RUN);
    halt_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // DRAIN abandoned when halt_req drops
    next_cycle();
    halt_req = 1'b1;
    next_cycle();
    halt_req = 1'b0;
    @(negedge clk); check("hd_in_drain", dbg_state, S_DRAIN);
    next_cycle();
    @(negedge clk); check("hd_back_run", dbg_state, S_RUN);

    // Branch in the first DRAIN cycle, then async reset mid-DRAIN
    next_cycle();
    halt_req = 1'b1;
    next_cycle();
    PCSrcE = 1'b1;
    @(negedge clk);
    check("hb_stallF", StallF, 0);
    check("hb_flushD", FlushD, 1);
    check("hb_flushE", FlushE, 1);
    check("hb_stallD", StallD, 1);
    next_cycle();
    PCSrcE = 1'b0;
    @(negedge clk);
    check("hb_after_stallF", StallF, 1);
    check("hb_after_flushD", FlushD, 0);
    check("hb_after_state", dbg_state, S_DRAIN);
    reset = 1'b0;
    #1;
    check("hb_areset_state", dbg_state, S_RUN);
    check("hb_areset_halted", halted, 0);
    halt_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    @(negedge clk); check("hb_post_stallF", StallF, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard, stall and sequencing controller for the 5-stage pipelined core. It produces the forwarding selects, per-stage stall/flush enables and the data-memory request for `DataPath`. It also runs two small sequential engines: a data-memory wait tracker with a timeout flag, and a halt/drain FSM that quiesces the pipeline on request without losing an instruction.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive memory-wait cycles after which `mem_err` sets.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute.
- RdM, RdW  in  5  destination registers in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  register-write enables in M and W.
- LoadE  in  1  instruction in E is a load (ResultSrcE == RESULT_MEM).
- PCSrcE  in  1  taken branch or jump resolved in E.
- MemReqM  in  1  instruction in M is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  level request to halt and drain.
- ForwardAE, ForwardBE  out  2  ALU operand selects: 00 register file, 10 ALUResultM, 01 ResultW.
- StallF, StallD, StallE, StallM  out  1  hold the PC / pipeline register feeding that stage.
- FlushD, FlushE, FlushW  out  1  load a bubble (all control zero) into that stage.
- dmem_req  out  1  data-memory access strobe.
- halted  out  1  pipeline drained and frozen.
- mem_err  out  1  sticky memory-timeout flag.

## Operation
- Forwarding (combinational), per operand X in {1, 2}:
  - If Rs*X*E ≠ 0, RegWriteM, and RdM == Rs*X*E, select 10.
  - Else if Rs*X*E ≠ 0, RegWriteW, and RdW == Rs*X*E, select 01.
  - Else select 00. M takes priority over W.
- Load-use: `lwstall` = LoadE & RdE ≠ 0 & (RdE == Rs1D | RdE == Rs2D) & !PCSrcE. It asserts StallF, StallD and FlushE.
- Branch: PCSrcE asserts FlushD and FlushE and suppresses lwstall.
- Memory wait:
  - `dmem_req` = MemReqM.
  - `memstall` = MemReqM & !dmem_ready. It asserts StallF/D/E/M and FlushW, and overrides every other stall/flush: FlushD/FlushE are 0 and StallF is 1 while memstall.
  - `wait_cnt` increments on each memstall cycle (saturating) and clears on any non-memstall cycle.
  - When `wait_cnt` == MEM_TIMEOUT−1 and memstall, `mem_err` sets. It stays set until reset. The stall is not aborted.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN → DRAIN when halt_req. `drain_cnt` loads 0.
  - DRAIN: StallF, StallD and FlushE assert. D holds its instruction while E receives bubbles.
  - DRAIN branch exception: if PCSrcE, StallF=0 and FlushD=1 that cycle, so the PC loads the target and the wrong-path D instruction is squashed.
  - DRAIN counting: `drain_cnt` increments on each non-memstall cycle. At `drain_cnt` == 2 with no memstall, go to HALTED.
  - DRAIN → RUN if halt_req drops. This is safe because D was held.
  - HALTED: StallF, StallD and FlushE are held; `halted` = 1. HALTED → RUN when halt_req == 0.
- Combined stalls: StallF/StallD = lwstall | memstall | (state ≠ RUN, except the DRAIN branch cycle for StallF). FlushE = (PCSrcE | lwstall | state ≠ RUN) & !memstall.

## Timing
- Reset (reset == 0) gives state RUN, `wait_cnt` 0, `drain_cnt` 0, `halted` 0, `mem_err` 0.
- All other outputs are combinational functions of inputs and state, with zero-cycle latency.
- Load-use costs exactly 1 bubble. A taken branch costs 2 squashed instructions.
- Memory handshake: `dmem_ready` is sampled in the same cycle as `dmem_req`. Ready in the first cycle means no stall. Each not-ready cycle adds one stall cycle.
- halt_req sampled high in cycle t gives DRAIN at t+1 and `halted` = 1 at t+4, plus any memstall cycles in between.
- `halted` falls one cycle after halt_req is sampled low.
- An asynchronous reset asserted mid-DRAIN or mid-wait returns all state to reset values immediately.

## Test plan
- Back-to-back ALU dependency (RdM=5, RegWriteM=1, Rs1E=5) → ForwardAE=10. The same with RdW=5 only → 01. Rs1E=0 with RdM=0 → 00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for exactly 1 cycle. Adding PCSrcE=1 → StallF=0, FlushD=FlushE=1.
- Memory wait: MemReqM=1, dmem_ready low for 3 cycles → 3 cycles of StallF/D/E/M=1 and FlushW=1, then release; `mem_err` stays 0.
- Timeout: dmem_ready held low for 16 cycles → `mem_err`=1 from cycle 16, sticky after ready rises; it clears only on reset.
- Halt: halt_req=1 at t → FlushE=1 from t+1, `halted`=1 at t+4. A 2-cycle memstall during DRAIN → `halted` at t+6. Dropping halt_req → RUN next cycle.
- Branch at DRAIN entry: PCSrcE=1 in the first DRAIN cycle → StallF=0, FlushD=1 that cycle, then StallF=1. Async reset mid-DRAIN → `halted`=0, state RUN.
